// File: rtl/alu_route_adder.sv
// alu_route_adder: registered 20-bit add with carry, b-bypass mux and 16-way destination demux
module alu_route_adder #(
  parameter int WIDTH = 20,
  parameter int NDEST = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sel,
  input  logic [3:0]       dst,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [WIDTH-1:0] o5,
  output logic [WIDTH-1:0] o6,
  output logic [WIDTH-1:0] o7,
  output logic [WIDTH-1:0] o8,
  output logic [WIDTH-1:0] o9,
  output logic [WIDTH-1:0] o10,
  output logic [WIDTH-1:0] o11,
  output logic [WIDTH-1:0] o12,
  output logic [WIDTH-1:0] o13,
  output logic [WIDTH-1:0] o14,
  output logic [WIDTH-1:0] o15,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             out_valid
);
  logic [WIDTH:0]                total;
  logic [WIDTH-1:0]              y;
  logic [NDEST-1:0][WIDTH-1:0]   o_q, o_d;
  logic [WIDTH-1:0]              result_q, result_d;
  logic                          c_out_q, c_out_d, out_valid_q, out_valid_d;
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    y = sel ? b : total[WIDTH-1:0];
    for (int i = 0; i < NDEST; i++)
      o_d[i] = (in_valid && dst == i[3:0]) ? y : o_q[i];
    result_d = in_valid ? y : result_q;
    c_out_d = in_valid ? total[WIDTH] : c_out_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= '0;
      result_q <= '0;
      c_out_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      o_q <= o_d;
      result_q <= result_d;
      c_out_q <= c_out_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign o0 = o_q[0];
  assign o1 = o_q[1];
  assign o2 = o_q[2];
  assign o3 = o_q[3];
  assign o4 = o_q[4];
  assign o5 = o_q[5];
  assign o6 = o_q[6];
  assign o7 = o_q[7];
  assign o8 = o_q[8];
  assign o9 = o_q[9];
  assign o10 = o_q[10];
  assign o11 = o_q[11];
  assign o12 = o_q[12];
  assign o13 = o_q[13];
  assign o14 = o_q[14];
  assign o15 = o_q[15];
  assign result = result_q;
  assign c_out = c_out_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_route_adder.sv
// tb_alu_route_adder: directed and random checks of alu_route_adder against an arithmetic reference model
module tb_alu_route_adder;
  logic clk = 1'b0;
  logic rst_n, in_valid, c_in, sel;
  logic [19:0] a, b;
  logic [3:0] dst;
  logic [19:0] o0, o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11, o12, o13, o14, o15;
  logic [19:0] result;
  logic c_out, out_valid;
  logic [19:0] dut_o [16];
  logic [19:0] exp_o [16];
  logic [19:0] exp_r;
  logic exp_c, exp_v;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  alu_route_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
    .sel(sel), .dst(dst),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
    .o8(o8), .o9(o9), .o10(o10), .o11(o11), .o12(o12), .o13(o13), .o14(o14), .o15(o15),
    .result(result), .c_out(c_out), .out_valid(out_valid)
  );

  assign dut_o[0] = o0;   assign dut_o[1] = o1;   assign dut_o[2] = o2;   assign dut_o[3] = o3;
  assign dut_o[4] = o4;   assign dut_o[5] = o5;   assign dut_o[6] = o6;   assign dut_o[7] = o7;
  assign dut_o[8] = o8;   assign dut_o[9] = o9;   assign dut_o[10] = o10; assign dut_o[11] = o11;
  assign dut_o[12] = o12; assign dut_o[13] = o13; assign dut_o[14] = o14; assign dut_o[15] = o15;

  task automatic clear_model();
    for (int i = 0; i < 16; i++) exp_o[i] = '0;
    exp_r = '0;
    exp_c = 1'b0;
    exp_v = 1'b0;
  endtask

  // One clock: present inputs, update the model at the edge, settle 1 time unit after it.
  task automatic step(input logic v, input logic [19:0] ta, input logic [19:0] tb2,
                      input logic tc, input logic ts, input logic [3:0] td);
    int unsigned s;
    logic [19:0] y;
    in_valid = v; a = ta; b = tb2; c_in = tc; sel = ts; dst = td;
    @(posedge clk);
    if (v) begin
      s = int'(ta) + int'(tb2) + int'(tc);
      y = ts ? tb2 : 20'(s % (1 << 20));
      exp_o[td] = y;
      exp_r = y;
      exp_c = (s >= (1 << 20));
    end
    exp_v = v;
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++)
      step(1'b1, 20'($urandom), 20'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (dut_o[i] !== 20'h0) begin bad++; $display("FAIL reset_async o%0d: got %h want 00000", i, dut_o[i]); end
    end
    total++;
    if ({result, c_out, out_valid} !== 22'h0) begin
      bad++; $display("FAIL reset_async misc: got r=%h c=%b v=%b want zeros", result, c_out, out_valid);
    end
    in_valid = 1'b1; a = 20'hFFFFF; b = 20'h12345; sel = 1'b1; dst = 4'd7;
    @(posedge clk); #1;
    total++;
    if ({o7, result, out_valid} !== 41'h0) begin
      bad++; $display("FAIL reset_ignore_valid: got o7=%h r=%h v=%b want zeros", o7, result, out_valid);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 20'($urandom), 20'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      total++;
      if ({result, c_out, out_valid, o0, o15} !== 62'h0) begin
        bad++; $display("FAIL reset_idle%0d: got r=%h c=%b v=%b want zeros", k, result, c_out, out_valid);
      end
    end
  endtask

  task automatic test_carry_out();
    step(1'b1, 20'hFFFFF, 20'h00001, 1'b0, 1'b0, 4'd3);
    total++;
    if ({o3, result, c_out, out_valid} !== {20'h0, 20'h0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL carry_out: got o3=%h r=%h c=%b v=%b want 00000 00000 1 1", o3, result, c_out, out_valid);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (dut_o[i] !== 20'h0) begin bad++; $display("FAIL carry_out_other o%0d: got %h want 00000", i, dut_o[i]); end
    end
  endtask

  task automatic test_carry_in();
    step(1'b1, 20'h12345, 20'h0000A, 1'b1, 1'b0, 4'd15);
    total++;
    if ({o15, result, c_out} !== {20'h12350, 20'h12350, 1'b0}) begin
      bad++; $display("FAIL carry_in: got o15=%h r=%h c=%b want 12350 12350 0", o15, result, c_out);
    end
  endtask

  task automatic test_bypass();
    step(1'b1, 20'h00010, 20'hABCDE, 1'b0, 1'b1, 4'd0);
    total++;
    if ({o0, result, c_out, out_valid} !== {20'hABCDE, 20'hABCDE, 1'b0, 1'b1}) begin
      bad++; $display("FAIL bypass: got o0=%h r=%h c=%b v=%b want ABCDE ABCDE 0 1", o0, result, c_out, out_valid);
    end
    step(1'b1, 20'hFFFFF, 20'h00002, 1'b0, 1'b1, 4'd1);
    total++;
    if ({o1, c_out} !== {20'h00002, 1'b1}) begin
      bad++; $display("FAIL bypass_carry: got o1=%h c=%b want 00002 1", o1, c_out);
    end
  endtask

  task automatic test_routing();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 20'(i), 20'h0, 1'b0, 1'b0, 4'(i));
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL routing_valid%0d: got %b want 1", i, out_valid); end
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (dut_o[i] !== 20'(i)) begin bad++; $display("FAIL routing o%0d: got %h want %h", i, dut_o[i], 20'(i)); end
    end
    step(1'b0, 20'h0, 20'h0, 1'b0, 1'b0, 4'd0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL routing_valid_end: got %b want 0", out_valid); end
  endtask

  task automatic test_hold_overwrite();
    step(1'b1, 20'h00111, 20'h0, 1'b0, 1'b0, 4'd5);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 20'($urandom), 20'($urandom), 1'($urandom), 1'($urandom), 4'd5);
      total++;
      if ({o5, result, out_valid} !== {20'h00111, 20'h00111, 1'b0}) begin
        bad++; $display("FAIL hold%0d: got o5=%h r=%h v=%b want 00111 00111 0", k, o5, result, out_valid);
      end
    end
    step(1'b1, 20'h00222, 20'h0, 1'b0, 1'b0, 4'd5);
    total++;
    if ({o5, o4, o6} !== {20'h00222, exp_o[4], exp_o[6]}) begin
      bad++; $display("FAIL overwrite: got o5=%h o4=%h o6=%h want 00222 %h %h", o5, o4, o6, exp_o[4], exp_o[6]);
    end
    in_valid = 1'b1; a = 20'h00333; b = 20'h0; sel = 1'b0; dst = 4'd5;
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    total++;
    if ({o5, o0, o15, result, c_out, out_valid} !== 82'h0) begin
      bad++; $display("FAIL midstream_reset: got o5=%h o0=%h r=%h v=%b want zeros", o5, o0, result, out_valid);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 3) != 0), 20'($urandom), 20'($urandom), 1'($urandom),
           1'($urandom), 4'($urandom));
      for (int i = 0; i < 16; i++) begin
        total++;
        if (dut_o[i] !== exp_o[i]) begin bad++; $display("FAIL random%0d o%0d: got %h want %h", k, i, dut_o[i], exp_o[i]); end
      end
      total++;
      if ({result, c_out, out_valid} !== {exp_r, exp_c, exp_v}) begin
        bad++; $display("FAIL random%0d misc: got r=%h c=%b v=%b want r=%h c=%b v=%b",
                        k, result, c_out, out_valid, exp_r, exp_c, exp_v);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sel = 1'b0; dst = '0;
    clear_model();
    #12 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_carry_out();
    test_carry_in();
    test_bypass();
    test_routing();
    test_hold_overwrite();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
